// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit.
//   - RV32I funct3 width/sign codes
//   - byte-strobe constants
//   - FSM state encoding
//   - helpers for request legality, alignment and store lane preparation
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] STRB_NONE    = 4'b0000;
    localparam logic [3:0] STRB_BYTE    = 4'b0001;
    localparam logic [3:0] STRB_HALF_LO = 4'b0011;
    localparam logic [3:0] STRB_HALF_HI = 4'b1100;
    localparam logic [3:0] STRB_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        WRITEBACK = 2'd2
    } lsu_state_t;

    // Stores only have signed-width encodings; the unsigned variants exist
    // for loads only.
    function automatic logic funct3Legal(input logic isStore, input logic [2:0] funct3);
        logic legal;
        case (funct3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = !isStore;
            default:          legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Byte accesses can never be misaligned; halfwords need an even address,
    // words need a word-aligned address.
    function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic mis;
        case (funct3)
            F3_H, F3_HU: mis = offset[0];
            F3_W:        mis = |offset;
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Byte enables for a store; the offset is already known to be aligned.
    function automatic logic [3:0] storeStrobe(input logic [2:0] funct3, input logic [1:0] offset);
        logic [3:0] strb;
        case (funct3)
            F3_B:    strb = STRB_BYTE << offset;
            F3_H:    strb = offset[1] ? STRB_HALF_HI : STRB_HALF_LO;
            F3_W:    strb = STRB_WORD;
            default: strb = STRB_NONE;
        endcase
        return strb;
    endfunction

    // Store data is replicated across every lane so the strobes alone decide
    // which bytes the memory actually writes.
    function automatic logic [31:0] storeLanes(input logic [2:0] funct3, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (funct3)
            F3_B:    lanes = {4{wdata[7:0]}};
            F3_H:    lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational load-data formatter: picks the addressed byte or halfword out
// of the returned memory word and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata_i  [31:0]  word returned by memory
//   addr_i   [1:0]   byte offset of the load within the word
//   funct3_i [2:0]   RV32I load width/sign code
//   data_o   [31:0]  aligned, extended register value
// -----------------------------------------------------------------------------
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Lane selection: the byte lane follows the full offset, the halfword lane
    // only needs offset bit 1 since halfword loads are already known aligned.
    always_comb begin
        byteSel = rdata_i[7:0];
        case (addr_i)
            2'd0:    byteSel = rdata_i[7:0];
            2'd1:    byteSel = rdata_i[15:8];
            2'd2:    byteSel = rdata_i[23:16];
            default: byteSel = rdata_i[31:24];
        endcase
        halfSel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Extension: signed codes replicate the top bit of the selected lane,
    // unsigned codes pad with zeros, words pass straight through.
    always_comb begin
        data_o = rdata_i;
        case (funct3_i)
            F3_B:    data_o = {{24{byteSel[7]}}, byteSel};
            F3_BU:   data_o = {24'h000000, byteSel};
            F3_H:    data_o = {{16{halfSel[15]}}, halfSel};
            F3_HU:   data_o = {16'h0000, halfSel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_writeback.sv
// -----------------------------------------------------------------------------
// lsu_writeback
// Load/store unit sitting between execute and data memory. Takes one request
// at a time, runs a word-addressed memory access with byte strobes, and for
// loads produces the register-file write port.
// Parameters:
//   TIMEOUT  ACCESS cycles without mem_ack_i before the access is aborted
//   CNT_W    width of the timeout counter
// Ports:
//   clk_i, reset_i                      clock, async active-high reset
//   req_valid_i / req_ready_o           request handshake
//   req_is_store_i, req_funct3_i,
//   req_addr_i, req_wdata_i, req_rd_i   request fields
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_wstrb_o            memory command (held until ack)
//   mem_ack_i, mem_rdata_i              memory response
//   wb_en_o, wb_reg_num_o, wb_data_o    register-file write port
//   err_misaligned_o, err_illegal_o,
//   err_timeout_o                       single-cycle error pulses
//   busy_o                              unit is not idle
// -----------------------------------------------------------------------------
module lsu_writeback
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_is_store_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        wb_en_o,
    output logic [4:0]  wb_reg_num_o,
    output logic [31:0] wb_data_o,
    output logic        err_misaligned_o,
    output logic        err_illegal_o,
    output logic        err_timeout_o,
    output logic        busy_o
);

    lsu_state_t       state_q, state_d;
    logic [CNT_W-1:0] timeoutCnt_q, timeoutCnt_d;

    logic [31:0] addr_q;
    logic [1:0]  byteOff_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [3:0]  strb_q;
    logic [31:0] wbData_q;
    logic [4:0]  wbRegNum_q;
    logic        errIllegal_q;
    logic        errMisaligned_q;

    logic        reqAccepted;
    logic        reqIllegal;
    logic        reqMisaligned;
    logic        reqGood;
    logic        timeoutHit;
    logic [31:0] alignedData;

    lsu_load_align u_align (
        .rdata_i  (mem_rdata_i),
        .addr_i   (byteOff_q),
        .funct3_i (funct3_q),
        .data_o   (alignedData)
    );

    // Request screening. Legality is checked before alignment, so an illegal
    // code never also reports a misalignment. The timeout fires on the ACCESS
    // cycle in which the count of ack-less cycles reaches TIMEOUT; an ack in
    // that same cycle masks it.
    always_comb begin
        reqAccepted   = req_valid_i && (state_q == IDLE);
        reqIllegal    = !funct3Legal(req_is_store_i, req_funct3_i);
        reqMisaligned = isMisaligned(req_funct3_i, req_addr_i[1:0]);
        reqGood       = reqAccepted && !reqIllegal && !reqMisaligned;
        timeoutHit    = (state_q == ACCESS) && !mem_ack_i &&
                        (timeoutCnt_q == CNT_W'(TIMEOUT - 1));
    end

    // Next-state logic. The counter is cleared whenever an access starts or
    // ends so every access gets the full TIMEOUT budget.
    always_comb begin
        state_d      = state_q;
        timeoutCnt_d = timeoutCnt_q;
        case (state_q)
            IDLE: begin
                if (reqGood) begin
                    state_d      = ACCESS;
                    timeoutCnt_d = '0;
                end
            end
            ACCESS: begin
                if (mem_ack_i) begin
                    state_d      = we_q ? IDLE : WRITEBACK;
                    timeoutCnt_d = '0;
                end else if (timeoutHit) begin
                    state_d      = IDLE;
                    timeoutCnt_d = '0;
                end else begin
                    timeoutCnt_d = timeoutCnt_q + 1'b1;
                end
            end
            WRITEBACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d      = IDLE;
                timeoutCnt_d = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            timeoutCnt_q <= '0;
        end else begin
            state_q      <= state_d;
            timeoutCnt_q <= timeoutCnt_d;
        end
    end

    // Request capture, load-result capture and the registered error pulses.
    // Store lanes and strobes are prepared at acceptance so the bus is stable
    // for the whole access; loads carry zero strobes. The writeback register
    // number and data only change when a load completes, so they keep their
    // values after the wb_en pulse.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            addr_q          <= '0;
            byteOff_q       <= '0;
            funct3_q        <= '0;
            rd_q            <= '0;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            strb_q          <= '0;
            wbData_q        <= '0;
            wbRegNum_q      <= '0;
            errIllegal_q    <= 1'b0;
            errMisaligned_q <= 1'b0;
        end else begin
            errIllegal_q    <= reqAccepted && reqIllegal;
            errMisaligned_q <= reqAccepted && !reqIllegal && reqMisaligned;
            if (reqGood) begin
                addr_q    <= {req_addr_i[31:2], 2'b00};
                byteOff_q <= req_addr_i[1:0];
                funct3_q  <= req_funct3_i;
                rd_q      <= req_rd_i;
                we_q      <= req_is_store_i;
                wdata_q   <= req_is_store_i ? storeLanes(req_funct3_i, req_wdata_i) : 32'h0;
                strb_q    <= req_is_store_i ? storeStrobe(req_funct3_i, req_addr_i[1:0]) : STRB_NONE;
            end
            if ((state_q == ACCESS) && mem_ack_i && !we_q) begin
                wbData_q   <= alignedData;
                wbRegNum_q <= rd_q;
            end
        end
    end

    // Output decode. Bus control is derived from the state so an asynchronous
    // reset drops mem_req immediately; a load to x0 completes its access but
    // never raises wb_en.
    always_comb begin
        req_ready_o      = (state_q == IDLE);
        busy_o           = (state_q != IDLE);
        mem_req_o        = (state_q == ACCESS);
        mem_we_o         = (state_q == ACCESS) && we_q;
        mem_addr_o       = addr_q;
        mem_wdata_o      = wdata_q;
        mem_wstrb_o      = (state_q == ACCESS) ? strb_q : STRB_NONE;
        wb_en_o          = (state_q == WRITEBACK) && (rd_q != 5'd0);
        wb_reg_num_o     = wbRegNum_q;
        wb_data_o        = wbData_q;
        err_illegal_o    = errIllegal_q;
        err_misaligned_o = errMisaligned_q;
        err_timeout_o    = timeoutHit;
    end

endmodule

// File: tb/tb_lsu_writeback.sv
// -----------------------------------------------------------------------------
// tb_lsu_writeback
// Scoreboard bench for lsu_writeback. The stimulus side issues requests, plays
// the memory, and pushes the bus command and result event it expects into
// queues; an independent monitor pops and compares whenever the DUT shows a
// memory access, a writeback or an error pulse.
// -----------------------------------------------------------------------------
module tb_lsu_writeback;

    localparam int TB_TIMEOUT = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_is_store_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        wb_en_o;
    logic [4:0]  wb_reg_num_o;
    logic [31:0] wb_data_o;
    logic        err_misaligned_o;
    logic        err_illegal_o;
    logic        err_timeout_o;
    logic        busy_o;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        cmpWdata;
        logic [3:0]  strb;
    } mem_t;

    // kind is one-hot {wb_en, err_illegal, err_misaligned, err_timeout}
    typedef struct {
        logic [3:0]  kind;
        logic [4:0]  rd;
        logic [31:0] data;
    } evt_t;

    mem_t expMem[$];
    evt_t expEvt[$];
    mem_t curMem;
    logic inAccess = 1'b0;

    int total = 0;
    int bad   = 0;

    lsu_writeback #(.TIMEOUT(TB_TIMEOUT), .CNT_W(8)) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_is_store_i   (req_is_store_i),
        .req_funct3_i     (req_funct3_i),
        .req_addr_i       (req_addr_i),
        .req_wdata_i      (req_wdata_i),
        .req_rd_i         (req_rd_i),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_wstrb_o      (mem_wstrb_o),
        .mem_ack_i        (mem_ack_i),
        .mem_rdata_i      (mem_rdata_i),
        .wb_en_o          (wb_en_o),
        .wb_reg_num_o     (wb_reg_num_o),
        .wb_data_o        (wb_data_o),
        .err_misaligned_o (err_misaligned_o),
        .err_illegal_o    (err_illegal_o),
        .err_timeout_o    (err_timeout_o),
        .busy_o           (busy_o)
    );

    // Free-running 10-unit clock.
    always #5 clk_i = ~clk_i;

    // Single comparison point; every check in the bench funnels through here.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge. The
    // first cycle of each access pops the expected command, which must then
    // hold every cycle until the access ends. Any pulse on the result outputs
    // pops one expected event.
    always @(negedge clk_i) begin
        logic [3:0] evVec;
        evt_t       e;
        if (reset_i) begin
            inAccess = 1'b0;
        end else begin
            if (mem_req_o) begin
                if (!inAccess) begin
                    if (expMem.size() == 0) begin
                        checkOutput("mem_req_unexpected", 64'(mem_req_o), 64'd0);
                    end else begin
                        curMem   = expMem.pop_front();
                        inAccess = 1'b1;
                    end
                end
                if (inAccess) begin
                    checkOutput("mem_we", 64'(mem_we_o), 64'(curMem.we));
                    checkOutput("mem_addr", 64'(mem_addr_o), 64'(curMem.addr));
                    checkOutput("mem_wstrb", 64'(mem_wstrb_o), 64'(curMem.strb));
                    if (curMem.cmpWdata)
                        checkOutput("mem_wdata", 64'(mem_wdata_o), 64'(curMem.wdata));
                end
            end else begin
                inAccess = 1'b0;
            end

            evVec = {wb_en_o, err_illegal_o, err_misaligned_o, err_timeout_o};
            if (evVec != 4'b0000) begin
                if (expEvt.size() == 0) begin
                    checkOutput("event_unexpected", 64'(evVec), 64'd0);
                end else begin
                    e = expEvt.pop_front();
                    checkOutput("event_kind", 64'(evVec), 64'(e.kind));
                    if (e.kind[3]) begin
                        checkOutput("wb_reg_num", 64'(wb_reg_num_o), 64'(e.rd));
                        checkOutput("wb_data", 64'(wb_data_o), 64'(e.data));
                    end
                    if (e.kind[0])
                        checkOutput("timeout_while_req", 64'(mem_req_o), 64'd1);
                end
            end
        end
    end

    // Waits for the unit to be ready, issues one request, predicts its bus
    // command and result from the load/store rules, then plays the memory:
    // ackDelay idle ACCESS cycles before the ack, or no ack at all when the
    // delay reaches the timeout.
    task automatic applyStimulus(input logic isStore, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] rd, input int ackDelay,
                                 input logic [31:0] rdata);
        int          guard;
        logic        legal;
        logic        mis;
        int          sz;
        int          off;
        logic [31:0] mask;
        logic [31:0] lv;
        mem_t        m;
        evt_t        e;

        guard = 0;
        while (req_ready_o !== 1'b1 && guard < 50) begin
            @(posedge clk_i); #1;
            guard++;
        end
        if (guard >= 50) begin
            checkOutput("ready_wait_expired", 64'(req_ready_o), 64'd1);
            return;
        end

        legal = isStore ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        sz    = 1 << f3[1:0];
        off   = int'(addr[1:0]);
        mis   = legal && ((off % sz) != 0);
        mask  = (sz >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);

        e.rd   = rd;
        e.data = 32'h0;
        if (!legal) begin
            e.kind = 4'b0100;
            expEvt.push_back(e);
        end else if (mis) begin
            e.kind = 4'b0010;
            expEvt.push_back(e);
        end else begin
            m.we       = isStore;
            m.addr     = addr & 32'hFFFF_FFFC;
            m.cmpWdata = isStore;
            m.wdata    = (sz == 1) ? (wdata & mask) * 32'h0101_0101 :
                         (sz == 2) ? (wdata & mask) * 32'h0001_0001 : wdata;
            m.strb     = isStore ? 4'(((1 << sz) - 1) << off) : 4'b0000;
            expMem.push_back(m);
            lv = (rdata >> (8 * off)) & mask;
            if (f3[2] == 1'b0 && sz < 4 && lv[8 * sz - 1])
                lv = lv | ~mask;
            if (ackDelay >= TB_TIMEOUT) begin
                e.kind = 4'b0001;
                expEvt.push_back(e);
            end else if (!isStore && rd != 5'd0) begin
                e.kind = 4'b1000;
                e.data = lv;
                expEvt.push_back(e);
            end
        end

        req_valid_i    = 1'b1;
        req_is_store_i = isStore;
        req_funct3_i   = f3;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        req_rd_i       = rd;
        @(posedge clk_i); #1;
        req_valid_i    = 1'b0;
        req_addr_i     = $urandom;
        req_wdata_i    = $urandom;

        if (!legal || mis) begin
            checkOutput("reject_no_mem_req", 64'(mem_req_o), 64'd0);
            checkOutput("reject_ready", 64'(req_ready_o), 64'd1);
            return;
        end

        if (ackDelay >= TB_TIMEOUT) begin
            repeat (TB_TIMEOUT) @(posedge clk_i);
            #1;
            checkOutput("timeout_mem_req_low", 64'(mem_req_o), 64'd0);
            checkOutput("timeout_ready", 64'(req_ready_o), 64'd1);
            checkOutput("timeout_no_wb", 64'(wb_en_o), 64'd0);
            return;
        end

        repeat (ackDelay) @(posedge clk_i);
        #0;
        mem_ack_i   = 1'b1;
        mem_rdata_i = rdata;
        @(posedge clk_i); #1;
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;

        if (isStore) begin
            checkOutput("store_done_ready", 64'(req_ready_o), 64'd1);
            checkOutput("store_done_no_req", 64'(mem_req_o), 64'd0);
            checkOutput("store_no_wb", 64'(wb_en_o), 64'd0);
        end else begin
            checkOutput("load_wb_pulse", 64'(wb_en_o), 64'(rd != 5'd0));
            @(posedge clk_i); #1;
            checkOutput("load_wb_single", 64'(wb_en_o), 64'd0);
            checkOutput("load_done_ready", 64'(req_ready_o), 64'd1);
            if (rd != 5'd0)
                checkOutput("load_wb_hold", 64'(wb_data_o), 64'(lv));
        end
    endtask

    // Starts a word load, then asserts reset in the middle of its second
    // ACCESS cycle; the bus must drop at once and nothing may be reported.
    task automatic applyResetMidAccess();
        int guard;
        mem_t m;
        guard = 0;
        while (req_ready_o !== 1'b1 && guard < 50) begin
            @(posedge clk_i); #1;
            guard++;
        end
        m.we = 1'b0; m.addr = 32'h0000_0300; m.wdata = 32'h0; m.cmpWdata = 1'b0; m.strb = 4'b0000;
        expMem.push_back(m);
        req_valid_i = 1'b1; req_is_store_i = 1'b0; req_funct3_i = 3'b010;
        req_addr_i  = 32'h0000_0300; req_rd_i = 5'd9;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;
        reset_i = 1'b1;
        #1;
        checkOutput("rst_mid_mem_req", 64'(mem_req_o), 64'd0);
        checkOutput("rst_mid_ready", 64'(req_ready_o), 64'd1);
        checkOutput("rst_mid_wb", 64'(wb_en_o), 64'd0);
        checkOutput("rst_mid_busy", 64'(busy_o), 64'd0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        mem_ack_i = 1'b1;
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        checkOutput("rst_after_no_wb", 64'(wb_en_o), 64'd0);
        checkOutput("rst_after_ready", 64'(req_ready_o), 64'd1);
    endtask

    // Hard stop in case something wedges the stimulus.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no_finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus: reset checks, directed cases, then randomized requests.
    initial begin
        logic        isStore;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [4:0]  rd;

        reset_i        = 1'b1;
        req_valid_i    = 1'b0;
        req_is_store_i = 1'b0;
        req_funct3_i   = 3'b000;
        req_addr_i     = 32'h0;
        req_wdata_i    = 32'h0;
        req_rd_i       = 5'd0;
        mem_ack_i      = 1'b0;
        mem_rdata_i    = 32'h0;

        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("reset_ready", 64'(req_ready_o), 64'd1);
        checkOutput("reset_busy", 64'(busy_o), 64'd0);
        checkOutput("reset_mem_ctl", 64'({mem_req_o, mem_we_o, mem_wstrb_o}), 64'd0);
        checkOutput("reset_mem_addr", 64'(mem_addr_o), 64'd0);
        checkOutput("reset_mem_wdata", 64'(mem_wdata_o), 64'd0);
        checkOutput("reset_wb", 64'({wb_en_o, wb_reg_num_o}), 64'd0);
        checkOutput("reset_wb_data", 64'(wb_data_o), 64'd0);
        checkOutput("reset_errs", 64'({err_misaligned_o, err_illegal_o, err_timeout_o}), 64'd0);
        reset_i = 1'b0;
        @(posedge clk_i); #1;

        applyStimulus(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 5'd0, 2, 32'h0);
        applyStimulus(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd5, 0, 32'h80FF_1234);
        applyStimulus(1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd5, 0, 32'h80FF_1234);
        applyStimulus(1'b0, 3'b101, 32'h0000_0102, 32'h0, 5'd6, 1, 32'h80FF_1234);
        applyStimulus(1'b0, 3'b001, 32'h0000_0101, 32'h0, 5'd7, 0, 32'h80FF_1234);
        applyStimulus(1'b0, 3'b011, 32'h0000_0100, 32'h0, 5'd7, 0, 32'h0);
        applyStimulus(1'b1, 3'b100, 32'h0000_0100, 32'h55, 5'd0, 0, 32'h0);
        applyStimulus(1'b1, 3'b000, 32'h0000_0002, 32'h0000_00AB, 5'd0, 1, 32'h0);
        applyStimulus(1'b1, 3'b001, 32'h0000_0006, 32'h0000_1234, 5'd0, 0, 32'h0);
        applyStimulus(1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd0, 1, 32'h1234_5678);
        applyStimulus(1'b0, 3'b010, 32'h0000_0204, 32'h0, 5'd3, 9, 32'h0);
        applyStimulus(1'b0, 3'b010, 32'h0000_0208, 32'h0, 5'd4, TB_TIMEOUT - 1, 32'hCAFE_F00D);
        applyStimulus(1'b0, 3'b001, 32'h0000_020E, 32'h0, 5'd8, 0, 32'h8001_7FFF);
        applyResetMidAccess();

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = $urandom;
                @(posedge clk_i); #1;
                mem_ack_i   = 1'b0;
            end
            isStore = 1'($urandom_range(0, 1));
            f3      = 3'($urandom_range(0, 7));
            addr    = $urandom;
            rd      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            applyStimulus(isStore, f3, addr, $urandom, rd, $urandom_range(0, 5), $urandom);
        end

        repeat (5) @(posedge clk_i);
        #1;
        checkOutput("mem_queue_drained", 64'(expMem.size()), 64'd0);
        checkOutput("evt_queue_drained", 64'(expEvt.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
